// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter driving a registered 2:1 output mux, with a bounded burst per owner.
// Optional per-source transfer counters (cnt0/cnt1) are enabled by defining MUX2_ARB_STATS_EN.
module mux2_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_sel,
  input  logic          out_ready,
  output logic [1:0]    grant
`ifdef MUX2_ARB_STATS_EN
  ,
  output logic [15:0]   cnt0,
  output logic [15:0]   cnt1
`endif
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] burst;
  logic          load;
  logic          xfer0;
  logic          xfer1;

  function automatic logic [BW-1:0] burst_next(input logic [BW-1:0] b, input logic same_owner);
    if (!same_owner)  return BW'(1);
    else if (b >= BMAX) return BMAX;
    else              return b + BW'(1);
  endfunction

  // Grant is suppressed while reset is asserted so ready drops immediately.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (in0_valid && in1_valid) grant = last ? 2'b01 : 2'b10;
          else if (in0_valid)         grant = 2'b01;
          else if (in1_valid)         grant = 2'b10;
        end
        OWN0: begin
          if (in0_valid && !(in1_valid && burst == BMAX)) grant = 2'b01;
          else if (in1_valid)                              grant = 2'b10;
        end
        OWN1: begin
          if (in1_valid && !(in0_valid && burst == BMAX)) grant = 2'b10;
          else if (in0_valid)                              grant = 2'b01;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign load      = !out_valid || out_ready;
  assign in0_ready = grant[0] && load;
  assign in1_ready = grant[1] && load;
  assign xfer0     = in0_valid && in0_ready;
  assign xfer1     = in1_valid && in1_ready;

  // A stalled output freezes arbitration state as well as the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= 1'b0;
    end else if (load) begin
      if (xfer0) begin
        state     <= OWN0;
        last      <= 1'b0;
        burst     <= burst_next(burst, state == OWN0);
        out_valid <= 1'b1;
        out_data  <= in0_data;
        out_sel   <= 1'b0;
      end else if (xfer1) begin
        state     <= OWN1;
        last      <= 1'b1;
        burst     <= burst_next(burst, state == OWN1);
        out_valid <= 1'b1;
        out_data  <= in1_data;
        out_sel   <= 1'b1;
      end else begin
        state     <= IDLE;
        burst     <= '0;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MUX2_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (xfer0) cnt0 <= cnt0 + 16'd1;
      if (xfer1) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: a MAX_BURST=4 instance plus a MAX_BURST=1 instance on shared inputs.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in0_data = '0, in1_data = '0;
  logic       in0_ready, in1_ready, out_valid, out_sel;
  logic [7:0] out_data;
  logic [1:0] grant;
  logic       b_in0_ready, b_in1_ready, b_out_valid, b_out_sel;
  logic [7:0] b_out_data;
  logic [1:0] b_grant;
`ifdef MUX2_ARB_STATS_EN
  logic [15:0] cnt0, cnt1, b_cnt0, b_cnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready), .grant(grant)
`ifdef MUX2_ARB_STATS_EN
    , .cnt0(cnt0), .cnt1(cnt1)
`endif
  );

  mux2_rr_arbiter #(.DW(8), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(b_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(b_in1_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sel(b_out_sel),
    .out_ready(out_ready), .grant(b_grant)
`ifdef MUX2_ARB_STATS_EN
    , .cnt0(b_cnt0), .cnt1(b_cnt1)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    apply_reset();
    n_cmp++; if ({out_valid, out_data, out_sel, grant} !== 12'h000) begin n_err++; $display("FAIL reset_idle: got %h required 000", {out_valid, out_data, out_sel, grant}); end
    in0_valid = 1'b1; in0_data = 8'h55; out_ready = 1'b0;
    tick();
    n_cmp++; if ({out_valid, out_data} !== 9'h155) begin n_err++; $display("FAIL reset_preload: got %h required 155", {out_valid, out_data}); end
    in1_valid = 1'b1; in1_data = 8'h66;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, out_data, out_sel, grant, in0_ready, in1_ready} !== 14'h0) begin n_err++; $display("FAIL reset_async: got %h required 0000", {out_valid, out_data, out_sel, grant, in0_ready, in1_ready}); end
    tick();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL reset_first_grant: got %b required 01", grant); end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_single_source;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in0_valid = 1'b1; in0_data = 8'h10 + 8'(i);
      #1;
      n_cmp++; if ({grant, in0_ready, in1_ready} !== 4'b0110) begin n_err++; $display("FAIL single_grant[%0d]: got %b required 0110", i, {grant, in0_ready, in1_ready}); end
      tick();
      n_cmp++; if ({out_valid, out_sel, out_data} !== {2'b10, 8'h10 + 8'(i)}) begin n_err++; $display("FAIL single_out[%0d]: got %h required %h", i, {out_valid, out_sel, out_data}, {2'b10, 8'h10 + 8'(i)}); end
    end
    in0_data = 8'h16; in1_valid = 1'b1; in1_data = 8'h99;
    #1;
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL burst_saturate_grant: got %b required 10", grant); end
    tick();
    n_cmp++; if ({out_sel, out_data} !== 9'h199) begin n_err++; $display("FAIL burst_saturate_out: got %h required 199", {out_sel, out_data}); end
    in0_valid = 1'b0; in1_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_contention;
    int e, eb;
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e  = (i / 4) % 2;
      eb = i % 2;
      in0_data = 8'hA0 + 8'(i); in1_data = 8'hB0 + 8'(i);
      #1;
      n_cmp++; if (grant !== (e ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL contend_grant[%0d]: got %b required %b", i, grant, (e ? 2'b10 : 2'b01)); end
      n_cmp++; if (b_grant !== (eb ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL alternate_grant[%0d]: got %b required %b", i, b_grant, (eb ? 2'b10 : 2'b01)); end
      tick();
      n_cmp++; if ({out_sel, out_data} !== {e[0], (e ? 8'hB0 : 8'hA0) + 8'(i)}) begin n_err++; $display("FAIL contend_out[%0d]: got %h required %h", i, {out_sel, out_data}, {e[0], (e ? 8'hB0 : 8'hA0) + 8'(i)}); end
      n_cmp++; if (b_out_sel !== eb[0]) begin n_err++; $display("FAIL alternate_sel[%0d]: got %b required %b", i, b_out_sel, eb[0]); end
    end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1; in0_data = 8'h30;
    tick();
    out_ready = 1'b0; in0_data = 8'h31;
    for (int i = 0; i < 3; i++) begin
      in1_valid = (i == 1); in1_data = 8'hEE;
      #1;
      n_cmp++; if ({grant, in0_ready, in1_ready} !== 4'b0100) begin n_err++; $display("FAIL stall_ready[%0d]: got %b required 0100", i, {grant, in0_ready, in1_ready}); end
      tick();
      n_cmp++; if ({out_valid, out_sel, out_data} !== 10'h230) begin n_err++; $display("FAIL stall_hold[%0d]: got %h required 230", i, {out_valid, out_sel, out_data}); end
    end
    in1_valid = 1'b0; out_ready = 1'b1;
    #1;
    n_cmp++; if (in0_ready !== 1'b1) begin n_err++; $display("FAIL resume_ready: got %b required 1", in0_ready); end
    tick();
    n_cmp++; if ({out_valid, out_sel, out_data} !== 10'h231) begin n_err++; $display("FAIL resume_out: got %h required 231", {out_valid, out_sel, out_data}); end
    in0_valid = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL resume_drain: got %b required 0", out_valid); end
  endtask

  task automatic test_owner_drop;
    apply_reset();
    out_ready = 1'b1; in1_valid = 1'b1; in1_data = 8'hC0;
    tick();
    in1_data = 8'hC1;
    tick();
    in1_valid = 1'b0; in0_valid = 1'b1; in0_data = 8'hD0;
    #1;
    n_cmp++; if ({grant, in0_ready} !== 3'b011) begin n_err++; $display("FAIL drop_grant: got %b required 011", {grant, in0_ready}); end
    tick();
    n_cmp++; if ({out_sel, out_data} !== 9'h0D0) begin n_err++; $display("FAIL drop_out: got %h required 0d0", {out_sel, out_data}); end
    in1_valid = 1'b1; in1_data = 8'hC2;
    for (int k = 1; k < 4; k++) begin
      in0_data = 8'hD0 + 8'(k);
      #1;
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL drop_restart_grant[%0d]: got %b required 01", k, grant); end
      tick();
      n_cmp++; if ({out_sel, out_data} !== {1'b0, 8'hD0 + 8'(k)}) begin n_err++; $display("FAIL drop_restart_out[%0d]: got %h required %h", k, {out_sel, out_data}, {1'b0, 8'hD0 + 8'(k)}); end
    end
    #1;
    n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL drop_handback: got %b required 10", grant); end
    tick();
    n_cmp++; if ({out_sel, out_data} !== 9'h1C2) begin n_err++; $display("FAIL drop_handback_out: got %h required 1c2", {out_sel, out_data}); end
    in0_valid = 1'b0; in1_valid = 1'b0;
  endtask

`ifdef MUX2_ARB_STATS_EN
  task automatic test_stats;
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1;
    repeat (5) tick();
    in0_valid = 1'b0; in1_valid = 1'b1;
    repeat (3) tick();
    in1_valid = 1'b0;
    tick();
    n_cmp++; if ({cnt0, cnt1} !== {16'd5, 16'd3}) begin n_err++; $display("FAIL stats_count: got %0d/%0d required 5/3", cnt0, cnt1); end
    apply_reset();
    out_ready = 1'b1; in0_valid = 1'b1;
    repeat (65535) tick();
    in0_valid = 1'b0;
    n_cmp++; if (cnt0 !== 16'hFFFF) begin n_err++; $display("FAIL stats_preload: got %h required ffff", cnt0); end
    in0_valid = 1'b1;
    tick();
    in0_valid = 1'b0;
    n_cmp++; if (cnt0 !== 16'h0000) begin n_err++; $display("FAIL stats_wrap: got %h required 0000", cnt0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_source();
    test_contention();
    test_backpressure();
    test_owner_drop();
`ifdef MUX2_ARB_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
